// File: rtl/operand_loader.sv
// Operand loader: debounces the entry/start buttons, writes switch operands into
// consecutive CPU registers, then issues one start request and tracks the run.

module operand_loader_debounce #(
   parameter logic [19:0] CYCLES = 20'd1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic deb_o
);
   logic        s1_q, s2_q, deb_q;
   logic [19:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
         // the level only moves after CYCLES consecutive differing samples
         if (s2_q == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CYCLES - 20'd1) begin
            deb_q <= s2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 20'd1;
         end
      end
   end

   assign deb_o = deb_q;
endmodule

module operand_loader #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
   parameter int          NUM_OPERANDS    = 4,
   parameter int          FIRST_REG       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        input_press,
   input  logic        start_press,
   input  logic [15:0] input_num,
   input  logic        cpu_done,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        start_req,
   output logic [2:0]  loaded_cnt,
   output logic [2:0]  phase
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WRITE   = 3'd1;
   localparam logic [2:0] S_RELEASE = 3'd2;
   localparam logic [2:0] S_ARMED   = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   // bit 0: operand entry button, bit 1: start button
   logic [1:0] raw, deb, deb_prev_q, evt_q;
   assign raw = {start_press, input_press};

   for (genvar g = 0; g < 2; g++) begin : g_btn
      operand_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .raw_i (raw[g]),
         .deb_o (deb[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_prev_q <= '0;
         evt_q      <= '0;
      end else begin
         deb_prev_q <= deb;
         evt_q      <= deb & ~deb_prev_q;
      end
   end

   logic [2:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        start_q, start_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      start_d = 1'b0;
      case (state_q)
         S_IDLE: if (evt_q[0]) begin
            data_d  = input_num;
            addr_d  = 5'(FIRST_REG) + {2'b00, cnt_q};
            state_d = S_WRITE;
         end
         S_WRITE: begin
            cnt_d   = cnt_q + 3'd1;
            state_d = S_RELEASE;
         end
         S_RELEASE: if (!deb[0]) begin
            state_d = (cnt_q == 3'(NUM_OPERANDS)) ? S_ARMED : S_IDLE;
         end
         S_ARMED: if (evt_q[1]) begin
            start_d = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: if (cpu_done) state_d = S_DONE;
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= 5'(FIRST_REG);
         data_q  <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         start_q <= start_d;
      end
   end

   assign wr_en      = (state_q == S_WRITE);
   assign wr_addr    = addr_q;
   assign wr_data    = {16'h0000, data_q};
   assign start_req  = start_q;
   assign loaded_cnt = cnt_q;
   assign phase      = state_q;
endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed and randomized button sequences checked
// against a transaction-level model of loads, arming, start and completion.

module tb_operand_loader;
   localparam int D  = 4;
   localparam int N  = 4;
   localparam int FR = 4;

   logic        clk = 1'b0, rst = 1'b1;
   logic        input_press = 1'b0, start_press = 1'b0, cpu_done = 1'b0;
   logic [15:0] input_num = 16'h0;
   logic        wr_en, start_req;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [2:0]  loaded_cnt, phase;

   int total = 0, passes = 0, fails = 0;
   int cyc = 0, st_cnt = 0, raise_c = 0;
   logic [36:0] obs_q[$];
   int          obs_edge[$];
   logic [36:0] exp_q[$];
   int mphase = 0, mcnt = 0, mstarts = 0;

   operand_loader #(.DEBOUNCE_CYCLES(20'(D)), .NUM_OPERANDS(N), .FIRST_REG(FR)) dut (
      .clk(clk), .rst(rst), .input_press(input_press), .start_press(start_press),
      .input_num(input_num), .cpu_done(cpu_done), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .start_req(start_req), .loaded_cnt(loaded_cnt), .phase(phase)
   );

   always #5 clk = ~clk;

   // record every write strobe cycle and every start pulse
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (wr_en !== 1'b0) begin
         obs_q.push_back({wr_addr, wr_data});
         obs_edge.push_back(cyc);
      end
      if (start_req !== 1'b0) st_cnt = st_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic compare_all(input string tag);
      logic [36:0] o, e;
      chk({tag, ".nwr"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         void'(obs_edge.pop_front());
         chk({tag, ".addr"}, 32'(o[36:32]), 32'(e[36:32]));
         chk({tag, ".data"}, o[31:0], e[31:0]);
      end
      obs_q.delete(); obs_edge.delete(); exp_q.delete();
      chk({tag, ".phase"}, 32'(phase), mphase);
      chk({tag, ".cnt"}, 32'(loaded_cnt), mcnt);
      chk({tag, ".starts"}, st_cnt, mstarts);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk({tag, ".rst_phase"}, 32'(phase), 0);
      chk({tag, ".rst_cnt"}, 32'(loaded_cnt), 0);
      chk({tag, ".rst_wren"}, 32'(wr_en), 0);
      chk({tag, ".rst_addr"}, 32'(wr_addr), FR);
      chk({tag, ".rst_data"}, wr_data, 0);
      chk({tag, ".rst_start"}, 32'(start_req), 0);
      input_press = 1'b0;
      start_press = 1'b0;
      cpu_done    = 1'b0;
      tick(3);
      rst = 1'b1;
      mphase = 0; mcnt = 0; mstarts = 0; st_cnt = 0;
      obs_q.delete(); obs_edge.delete(); exp_q.delete();
      tick(1);
   endtask

   // full press/release; only an idle loader with room accepts the operand
   task automatic press(input logic [15:0] v, input int hold);
      @(negedge clk);
      input_num   = v;
      input_press = 1'b1;
      raise_c     = cyc;
      if (mphase == 0) begin
         exp_q.push_back({5'(FR + mcnt), 16'h0, v});
         mcnt++;
         if (mcnt == N) mphase = 3;
      end
      tick(hold);
      input_press = 1'b0;
      input_num   = 16'($urandom);
      tick(D + 6);
   endtask

   task automatic glitch(input int len);
      @(negedge clk);
      input_press = 1'b1;
      tick(len);
      input_press = 1'b0;
      tick(D + 4);
   endtask

   task automatic start(input int hold);
      @(negedge clk);
      start_press = 1'b1;
      if (mphase == 3) begin
         mphase = 4;
         mstarts++;
      end
      tick(hold);
      start_press = 1'b0;
      tick(D + 6);
   endtask

   task automatic done_pulse();
      @(negedge clk);
      cpu_done = 1'b1;
      if (mphase == 4) mphase = 5;
      @(negedge clk);
      cpu_done = 1'b0;
      tick(2);
   endtask

   initial begin
      logic [15:0] v;
      int          op;
      bit          reached;

      do_reset("init");

      // single operand with exact strobe timing
      press(16'hBEEF, 10);
      if (obs_edge.size() > 0) chk("single.edge", obs_edge[0], raise_c + D + 4);
      else chk("single.edge", 0, raise_c + D + 4);
      compare_all("single");

      start(D + 6);
      compare_all("start_idle");

      for (int l = 1; l < D; l++) begin
         glitch(l);
         compare_all("glitch");
      end

      // full load with 1..4, then an ignored fifth press
      do_reset("full");
      for (int i = 1; i <= N; i++) begin
         press(16'(i), $urandom_range(D + 5, D + 12));
         compare_all("load");
      end
      press(16'($urandom), D + 6);
      compare_all("fifth");
      done_pulse();
      compare_all("done_armed");
      start(D + 10);
      compare_all("run");
      done_pulse();
      compare_all("done");
      press(16'($urandom), D + 6);
      compare_all("press_done");

      // reset while in RELEASE after the second operand
      do_reset("mid");
      press(16'($urandom), D + 6);
      compare_all("mid1");
      @(negedge clk);
      v = 16'($urandom);
      input_num   = v;
      input_press = 1'b1;
      exp_q.push_back({5'(FR + 1), 16'h0, v});
      mcnt = 2;
      mphase = 2;
      reached = 1'b0;
      for (int t = 0; t < 40 && !reached; t++) begin
         tick(1);
         if (phase === 3'd2) reached = 1'b1;
      end
      chk("mid.reach_release", 32'(reached), 1);
      compare_all("mid2");
      do_reset("midrst");
      chk("mid.after_cnt", 32'(loaded_cnt), 0);
      v = 16'($urandom);
      press(v, D + 7);
      compare_all("mid_again");

      // randomized operation mix against the model
      do_reset("rand");
      repeat (24) begin
         op = $urandom_range(0, 9);
         if (op < 5)      press(16'($urandom), $urandom_range(D + 5, D + 12));
         else if (op < 6) glitch($urandom_range(1, D - 1));
         else if (op < 8) start($urandom_range(D + 2, D + 10));
         else             done_pulse();
         compare_all("rand");
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream input stage of the single-cycle CPU board top: debounces the operand-entry and start buttons, writes each switch value as a zero-extended 32-bit word into consecutive CPU registers through the register admin port, then issues a single start request and tracks the run until the CPU reports completion. Its `phase` output drives the VGA status screen.

## Interface
- `DEBOUNCE_CYCLES`, 20'd1_000_000: consecutive stable synchronized samples needed to accept a button level change (≥1).
- `NUM_OPERANDS`, 4: operands collected before arming (1–7).
- `FIRST_REG`, 4: register index of the first operand; FIRST_REG+NUM_OPERANDS ≤ 32.
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `input_press` input 1: raw operand-entry button, asynchronous, active-high.
- `start_press` input 1: raw start button, asynchronous, active-high.
- `input_num` input 16: switch operand value, quasi-static.
- `cpu_done` input 1: one-cycle completion pulse from the CPU wrapper.
- `wr_en` output 1: register admin write strobe, one cycle per operand.
- `wr_addr` output 5: register index being written.
- `wr_data` output 32: {16'b0, captured input_num}.
- `start_req` output 1: one-cycle pulse requesting the CPU run.
- `loaded_cnt` output 3: operands written so far.
- `phase` output 3: FSM state encoding for display.

## Operation
- Each button: 2-flop synchronizer (s1, s2), then debouncer with level `deb` and counter. If s2 == deb, counter clears. Otherwise counter increments; when counter == DEBOUNCE_CYCLES-1 while s2 != deb, deb <= s2 and counter clears. Glitches shorter than DEBOUNCE_CYCLES samples never change deb.
- Press event = deb & ~deb_prev, registered one cycle. Release = deb low.
- FSM (`phase` value):
  - IDLE (0): on input event, capture input_num into data register -> WRITE.
  - WRITE (1): wr_en=1, wr_addr=FIRST_REG+loaded_cnt, wr_data={16'b0,captured}; loaded_cnt increments at exit edge -> RELEASE.
  - RELEASE (2): wait for input deb low; then -> ARMED if loaded_cnt == NUM_OPERANDS, else IDLE.
  - ARMED (3): on start event -> RUN; start_req=1 for the first RUN cycle only.
  - RUN (4): on cpu_done -> DONE.
  - DONE (5): terminal until reset.
- Outputs are Moore (registered state); wr_addr/wr_data hold their last values outside WRITE; wr_en low outside WRITE.
- loaded_cnt never exceeds NUM_OPERANDS; no further writes after ARMED.
- Ignored events: start events in IDLE/WRITE/RELEASE; input events in ARMED/RUN/DONE; cpu_done outside RUN. Simultaneous input and start events are resolved by state alone.
- Holding input_press does not repeat writes; one write per press/release cycle.

## Timing
- Reset (rst low, async): phase=0, loaded_cnt=0, wr_en=0, wr_addr=FIRST_REG, wr_data=0, start_req=0, synchronizers, deb and counters cleared. Reset mid-write aborts; no partial strobe after deassertion.
- Button raised before edge k and held: s2=1 after edge k+1; deb=1 after edge k+DEBOUNCE_CYCLES+1; event high the following cycle; FSM enters WRITE at edge k+DEBOUNCE_CYCLES+3; wr_en high exactly one cycle.
- input_num is sampled at the edge entering WRITE; later switch changes do not affect that write.
- Release accepted DEBOUNCE_CYCLES+2 edges after the raw drop; RELEASE->IDLE/ARMED on the next edge.
- start_req: single cycle, start event to RUN in 1 edge. RUN->DONE on the edge sampling cpu_done.

## Test plan
- Reset values: rst low asynchronously mid-cycle -> all outputs at reset values immediately, phase=0, wr_addr=4.
- Single operand (DEBOUNCE_CYCLES=4): input_num=16'hBEEF, press held 10 cycles -> exactly one wr_en, wr_addr=4, wr_data=32'h0000_BEEF, at edge k+7; loaded_cnt=1.
- Glitch rejection: input_press pulses of 1–3 cycles -> no wr_en, phase stays 0.
- Full load: four press/release cycles with 1,2,3,4 -> writes to regs 4,5,6,7 with those values; phase=3; fifth press -> no write.
- Start/run: start_press in phase 0 ignored; after arming, start held -> one start_req pulse, phase=4; cpu_done -> phase=5; cpu_done in phase 3 ignored.
- Reset mid-operation: rst low during RELEASE after 2 operands -> loaded_cnt=0, phase=0; subsequent press writes reg 4.
